// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC phase sequencer slice.
// Holds the sequencer FSM encoding and the default word width.
package cordic_pkg;

  localparam int DEFAULT_BIT_WIDTH      = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  // Counter width that can reach n-1 and is never zero bits wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_phase_sequencer_if.sv
// Bundle of control, cosine-stage and sample-stream signals around the sequencer.
// master = sequencer view, slave = surrounding logic (controller, cosine stage, consumer).
interface cordic_phase_sequencer_if
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
);

  logic                 enable;
  logic [BIT_WIDTH-1:0] phase_inc;
  logic                 phase_load;
  logic [BIT_WIDTH-1:0] phase_init;

  logic                 cos_start;
  logic [BIT_WIDTH-1:0] cos_angle;
  logic                 cos_ready;
  logic                 cos_done;
  logic [BIT_WIDTH-1:0] cos_value;

  logic                 sample_valid;
  logic                 sample_ready;
  logic [BIT_WIDTH-1:0] sample_data;
  logic [BIT_WIDTH-1:0] sample_phase;
  logic                 timeout_err;

  modport master (
    input  enable, phase_inc, phase_load, phase_init,
    input  cos_ready, cos_done, cos_value, sample_ready,
    output cos_start, cos_angle, sample_valid, sample_data, sample_phase, timeout_err
  );

  modport slave (
    output enable, phase_inc, phase_load, phase_init,
    output cos_ready, cos_done, cos_value, sample_ready,
    input  cos_start, cos_angle, sample_valid, sample_data, sample_phase, timeout_err
  );

endinterface

// File: rtl/cordic_phase_acc.sv
// Phase accumulator: modulo-2^BIT_WIDTH increment on advance, with load taking priority.
// The value presented on acc during an advance cycle is the angle being issued.
module cordic_phase_acc
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] init,
  input  logic                 advance,
  input  logic [BIT_WIDTH-1:0] inc,
  output logic [BIT_WIDTH-1:0] acc
);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= init;
    end else if (advance) begin
      acc <= acc + inc;
    end
  end

endmodule

// File: rtl/cordic_phase_sequencer.sv
// Issues phase-stepped angles to a multi-cycle cosine stage and returns each result
// as a held valid/ready sample, aborting with a sticky flag if cos_done never arrives.
module cordic_phase_sequencer
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH      = DEFAULT_BIT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  cordic_phase_sequencer_if.master  bus
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e           state, state_next;
  logic [CNT_W-1:0]     wait_cnt, wait_cnt_next;
  logic                 issue, capture, accept, timeout_hit;
  logic [BIT_WIDTH-1:0] phase_acc;
  logic [BIT_WIDTH-1:0] pending_phase;

  cordic_phase_acc #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_phase_acc (
    .clk     (clk),
    .reset   (reset),
    .load    (bus.phase_load),
    .init    (bus.phase_init),
    .advance (issue),
    .inc     (bus.phase_inc),
    .acc     (phase_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    issue         = 1'b0;
    capture       = 1'b0;
    accept        = 1'b0;
    timeout_hit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        wait_cnt_next = '0;
        if (bus.enable && bus.cos_ready) begin
          issue      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      // cos_ready lags cos_start by a cycle here, so only cos_done is trusted.
      ST_WAIT: begin
        if (bus.cos_done) begin
          capture       = 1'b1;
          wait_cnt_next = '0;
          state_next    = ST_HOLD;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_hit   = 1'b1;
          wait_cnt_next = '0;
          state_next    = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.sample_valid && bus.sample_ready) begin
          accept     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cos_start    <= 1'b0;
      bus.cos_angle    <= '0;
      pending_phase    <= '0;
      bus.sample_valid <= 1'b0;
      bus.sample_data  <= '0;
      bus.sample_phase <= '0;
      bus.timeout_err  <= 1'b0;
    end else begin
      bus.cos_start <= issue;
      if (issue) begin
        bus.cos_angle <= phase_acc;
        pending_phase <= phase_acc;
      end
      if (capture) begin
        bus.sample_data  <= bus.cos_value;
        bus.sample_phase <= pending_phase;
        bus.sample_valid <= 1'b1;
      end else if (accept) begin
        bus.sample_valid <= 1'b0;
      end
      if (timeout_hit) begin
        bus.timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Directed bench for cordic_phase_sequencer: a cosine-stage model answers cos_start,
// stimulus queues expected samples, and a negedge monitor scores each accepted sample.
module tb_cordic_phase_sequencer;
  import cordic_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 10;
  localparam int TO  = 64;

  typedef struct {
    logic [W-1:0] phase;
    logic [W-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cordic_phase_sequencer_if #(.BIT_WIDTH(W)) bus ();

  cordic_phase_sequencer #(
    .BIT_WIDTH      (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec       = 0;
  int n_err       = 0;
  int n_start     = 0;
  int n_samples   = 0;
  int cyc         = 0;
  int last_start  = -1000;
  int last_gap    = 0;
  logic prev_start = 1'b0;
  logic saw_valid  = 1'b0;

  exp_t         exp_q[$];
  logic [W-1:0] start_q[$];

  logic         model_respond = 1'b1;
  logic         inject_done   = 1'b0;
  logic [W-1:0] inject_value  = '0;

  // Hand-tabulated Q1.31 cosine values for the angles the vectors use.
  function automatic logic [W-1:0] cos_lookup(input logic [W-1:0] angle);
    case (angle)
      32'h0000_0000: return 32'h7FFF_FFFF;
      32'h2000_0000: return 32'h5A82_799A;
      32'h4000_0000: return 32'h0000_0000;
      32'h8000_0000: return 32'h8000_0001;
      32'hC000_0000: return 32'h0000_0000;
      default:       return angle ^ 32'h0F0F_0F0F;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] phase);
    exp_t e;
    e.phase = phase;
    e.data  = cos_lookup(phase);
    exp_q.push_back(e);
  endtask

  task automatic wait_starts(input int target, input string name);
    int k;
    k = 0;
    while (n_start < target && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_start < target) begin
      n_vec++; n_err++;
      $display("FAIL %s: wait expired with %0d cos_start pulses, expected %0d", name, n_start, target);
    end
  endtask

  task automatic wait_samples(input int target, input string name);
    int k;
    k = 0;
    while (n_samples < target && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_samples < target) begin
      n_vec++; n_err++;
      $display("FAIL %s: wait expired with %0d samples, expected %0d", name, n_samples, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cos_start"},    32'(bus.cos_start),    '0);
    check({tag, "_cos_angle"},    bus.cos_angle,         '0);
    check({tag, "_sample_valid"}, 32'(bus.sample_valid), '0);
    check({tag, "_sample_data"},  bus.sample_data,       '0);
    check({tag, "_sample_phase"}, bus.sample_phase,      '0);
    check({tag, "_timeout_err"},  32'(bus.timeout_err),  '0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cosine-stage model: fixed LAT-cycle latency, registered ready/done.
  initial begin
    int           cnt;
    logic         busy;
    logic [W-1:0] ang;
    cnt = 0; busy = 1'b0; ang = '0;
    bus.cos_ready = 1'b1;
    bus.cos_done  = 1'b0;
    bus.cos_value = '0;
    forever begin
      @(posedge clk); #1;
      bus.cos_done = 1'b0;
      if (reset) begin
        busy          = 1'b0;
        bus.cos_ready = 1'b1;
      end else begin
        if (inject_done) begin
          bus.cos_done  = 1'b1;
          bus.cos_value = inject_value;
          inject_done   = 1'b0;
        end
        if (busy) begin
          if (cnt == 1) begin
            busy          = 1'b0;
            bus.cos_ready = 1'b1;
            if (model_respond) begin
              bus.cos_done  = 1'b1;
              bus.cos_value = cos_lookup(ang);
            end
          end else begin
            cnt--;
          end
        end else if (bus.cos_start) begin
          busy          = 1'b1;
          cnt           = LAT;
          ang           = bus.cos_angle;
          bus.cos_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: start-pulse bookkeeping and scoreboard comparison on each handshake.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus.cos_start) begin
        check("cos_start_back_to_back", 32'(prev_start), '0);
        start_q.push_back(bus.cos_angle);
        last_gap   = cyc - last_start;
        last_start = cyc;
        n_start++;
      end
      if (bus.sample_valid) saw_valid = 1'b1;
      if (bus.sample_valid && bus.sample_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_sample: phase 0x%08h data 0x%08h, none expected",
                   bus.sample_phase, bus.sample_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sample_phase", bus.sample_phase, e.phase);
          check("sample_data",  bus.sample_data,  e.data);
        end
        n_samples++;
      end
    end
    prev_start = bus.cos_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int           base_s, base_n, t_start, t_to, k;
    logic         stable;
    logic [W-1:0] held_data, held_phase, got;
    logic [W-1:0] want_angle[2];

    bus.enable       = 1'b0;
    bus.phase_inc    = '0;
    bus.phase_load   = 1'b0;
    bus.phase_init   = '0;
    bus.sample_ready = 1'b0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Quarter-turn stepping with wrap from 0xC0000000 back to 0.
    @(posedge clk); #1;
    bus.phase_inc    = 32'h4000_0000;
    bus.sample_ready = 1'b1;
    push_exp(32'h0000_0000);
    push_exp(32'h4000_0000);
    push_exp(32'h8000_0000);
    push_exp(32'hC000_0000);
    push_exp(32'h0000_0000);
    bus.enable = 1'b1;
    wait_samples(5, "quarter_steps");
    bus.enable = 1'b0;
    check("issue_period", 32'(last_gap), 32'(LAT + 3));
    repeat (20) @(posedge clk); #1;
    check("quarter_starts", 32'(n_start), 32'd5);

    // Back-pressure: sample held stable for 20 cycles, next issue only after acceptance.
    base_s = n_start;
    base_n = n_samples;
    bus.sample_ready = 1'b0;
    push_exp(32'h4000_0000);
    push_exp(32'h8000_0000);
    bus.enable = 1'b1;
    k = 0;
    while (!bus.sample_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("hold_valid_seen", 32'(bus.sample_valid), 32'd1);
    held_data  = bus.sample_data;
    held_phase = bus.sample_phase;
    stable     = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!bus.sample_valid || bus.sample_data !== held_data || bus.sample_phase !== held_phase)
        stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_no_start", 32'(n_start), 32'(base_s + 1));
    @(posedge clk); #1;
    bus.sample_ready = 1'b1;
    wait_samples(base_n + 2, "hold_release");
    bus.enable = 1'b0;
    check("hold_starts", 32'(n_start), 32'(base_s + 2));
    repeat (15) @(posedge clk); #1;

    // phase_load coinciding with an issue: old angle goes out, load overrides the step.
    bus.phase_load = 1'b1;
    bus.phase_init = 32'h4000_0000;
    @(posedge clk); #1;
    bus.phase_load = 1'b0;
    start_q.delete();
    base_s = n_start;
    base_n = n_samples;
    push_exp(32'h4000_0000);
    push_exp(32'h2000_0000);
    bus.enable     = 1'b1;
    bus.phase_load = 1'b1;
    bus.phase_init = 32'h2000_0000;
    @(posedge clk); #1;
    bus.phase_load = 1'b0;
    wait_starts(base_s + 2, "load_issue");
    bus.enable     = 1'b0;
    // A load while a conversion is in flight must not touch its pending angle.
    bus.phase_load = 1'b1;
    bus.phase_init = 32'h0000_0000;
    @(posedge clk); #1;
    bus.phase_load = 1'b0;
    wait_samples(base_n + 2, "load_samples");
    want_angle[0] = 32'h4000_0000;
    want_angle[1] = 32'h2000_0000;
    for (int i = 0; i < 2; i++) begin
      got = (start_q.size() > 0) ? start_q.pop_front() : 32'hXXXX_XXXX;
      check($sformatf("load_angle_%0d", i), got, want_angle[i]);
    end
    repeat (15) @(posedge clk); #1;

    // Timeout: cosine stage never answers.
    model_respond = 1'b0;
    base_s = n_start;
    base_n = n_samples;
    bus.enable = 1'b1;
    wait_starts(base_s + 1, "timeout_issue");
    t_start = last_start;
    k = 0;
    while (!bus.timeout_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    t_to = cyc;
    check("timeout_flag", 32'(bus.timeout_err), 32'd1);
    check("timeout_cycles", 32'(t_to - t_start), 32'(TO));
    wait_starts(base_s + 2, "timeout_reissue");
    bus.enable = 1'b0;
    check("timeout_reissue_cycle", 32'(last_start), 32'(t_to + 1));
    repeat (80) @(posedge clk); #1;
    check("timeout_sticky", 32'(bus.timeout_err), 32'd1);
    check("timeout_no_sample", 32'(n_samples), 32'(base_n));
    model_respond = 1'b1;

    // Reset 3 cycles into WAIT, then a stray cos_done.
    base_s = n_start;
    bus.enable = 1'b1;
    wait_starts(base_s + 1, "reset_issue");
    bus.enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset        = 1'b0;
    saw_valid    = 1'b0;
    inject_value = 32'h1234_5678;
    inject_done  = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("reset_no_valid", 32'(saw_valid), '0);
    check_reset_outputs("post_reset");

    // enable drops 2 cycles after cos_start: exactly one sample, no further issue.
    base_s = n_start;
    base_n = n_samples;
    push_exp(32'h0000_0000);
    @(posedge clk); #1;
    bus.enable = 1'b1;
    wait_starts(base_s + 1, "enable_drop_issue");
    @(posedge clk); #1;
    bus.enable = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("enable_drop_samples", 32'(n_samples), 32'(base_n + 1));
    check("enable_drop_starts", 32'(n_start), 32'(base_s + 1));
    check("scoreboard_drained", 32'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_phase_sequencer.md
CORDIC_PHASE_SEQUENCER -- requirements
Module: cordic_phase_sequencer

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 32, giving the width of the phase word and of the sample word.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum number of cycles to wait for cos_done before aborting.
REQ-003 The block SHALL have the port clk  input  1  the single clock, rising edge.
REQ-004 The block SHALL have the port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have the port enable  input  1  level; while high, new conversions may be issued.
REQ-006 The block SHALL have the port phase_inc  input  BIT_WIDTH  unsigned per-sample phase step; full turn = 2^BIT_WIDTH.
REQ-007 The block SHALL have the port phase_load  input  1  single-cycle pulse that loads phase_init into the accumulator.
REQ-008 The block SHALL have the port phase_init  input  BIT_WIDTH  value loaded by phase_load.
REQ-009 The block SHALL have the port cos_start  output  1  start pulse to the downstream cosine stage.
REQ-010 The block SHALL have the port cos_angle  output  BIT_WIDTH  angle to the cosine stage, with the top 2 bits as the quadrant.
REQ-011 The block SHALL have the port cos_ready  input  1  registered ready from the cosine stage.
REQ-012 The block SHALL have the port cos_done  input  1  registered done from the cosine stage; cos_value is valid when cos_done is high.
REQ-013 The block SHALL have the port cos_value  input  BIT_WIDTH  signed cosine result.
REQ-014 The block SHALL have the port sample_valid  output  1  output sample valid.
REQ-015 The block SHALL have the port sample_ready  input  1  consumer accepts the sample.
REQ-016 The block SHALL have the port sample_data  output  BIT_WIDTH  signed captured cos_value.
REQ-017 The block SHALL have the port sample_phase  output  BIT_WIDTH  the angle that produced sample_data.
REQ-018 The block SHALL have the port timeout_err  output  1  sticky flag set on a cos_done timeout.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT and HOLD.
REQ-020 In IDLE, when enable=1 and cos_ready=1, the block SHALL assert cos_start for exactly one cycle with cos_angle=phase_acc, latch that angle as pending_phase, advance phase_acc by phase_inc modulo 2^BIT_WIDTH, and enter WAIT.
REQ-021 cos_start SHALL never be high outside that IDLE issue cycle, and SHALL never be high on two consecutive cycles.
REQ-022 cos_angle SHALL hold its value from the issue cycle until the next issue.
REQ-023 In WAIT, the block SHALL ignore cos_ready (it is stale by one cycle) and act only on cos_done.
REQ-024 In WAIT, on the first cycle with cos_done=1, the block SHALL capture sample_data<=cos_value and sample_phase<=pending_phase, set sample_valid=1 on the next cycle, and enter HOLD.
REQ-025 In WAIT, a cycle counter SHALL count from 0; if it reaches TIMEOUT_CYCLES-1 without cos_done, the block SHALL set timeout_err=1, discard the conversion and return to IDLE.
REQ-026 In HOLD, sample_valid, sample_data and sample_phase SHALL remain stable until the cycle in which sample_valid=1 and sample_ready=1, after which sample_valid SHALL be 0 and the FSM SHALL be in IDLE.
REQ-027 The latency from cos_done to sample_valid SHALL be 1 cycle; the minimum period between consecutive cos_start pulses SHALL be (cordic latency + 3) cycles.
REQ-028 phase_load=1 SHALL set phase_acc<=phase_init in any state; when it coincides with an issue, the issued angle SHALL be the old phase_acc and phase_init SHALL override the increment.
REQ-029 phase_load SHALL NOT alter pending_phase or the held sample.
REQ-030 When enable falls during WAIT or HOLD, the in-flight sample SHALL complete and be delivered normally, and no new issue SHALL occur.
REQ-031 phase_acc SHALL wrap silently, e.g. 0xC000_0000 + 0x4000_0000 = 0x0000_0000, with no flag.
REQ-032 cos_done observed in IDLE or HOLD SHALL be ignored.
REQ-033 timeout_err SHALL be cleared only by reset.

Reset
REQ-034 Reset SHALL force state=IDLE, phase_acc=0, pending_phase=0, cos_start=0, cos_angle=0, sample_valid=0, sample_data=0, sample_phase=0, timeout_err=0 and the timeout counter=0.
REQ-035 Reset asserted mid-WAIT SHALL abandon the conversion, so that any later cos_done is ignored and produces no sample.

Structure
REQ-036 The FSM state enum and the default BIT_WIDTH SHALL be defined in the shared package cordic_pkg.
REQ-037 The phase accumulator (load, increment, wrap) SHALL be a separate sub-module named cordic_phase_acc.
REQ-038 All outputs SHALL be driven from registers.

Verification
REQ-039 With phase_inc=0x4000_0000, enable=1, sample_ready=1 and a 10-cycle cosine model, the sample_phase values SHALL be 0x0, 0x40000000, 0x80000000, 0xC0000000, 0x0, and each sample_data SHALL equal the model output.
REQ-040 With sample_ready held 0 for 20 cycles after the first sample, sample_valid and sample_data SHALL stay stable, cos_start SHALL not pulse, and the next sample SHALL issue after acceptance.
REQ-041 With phase_load=1 and phase_init=0x2000_0000 on the issue cycle when phase_acc=0x4000_0000, the issued angle SHALL be 0x40000000 and the next issued angle SHALL be 0x20000000.
REQ-042 With the cosine model never asserting cos_done, timeout_err SHALL rise after 64 cycles in WAIT, the FSM SHALL be in IDLE and a fresh cos_start SHALL follow when cos_ready=1.
REQ-043 With reset asserted 3 cycles into WAIT and cos_done pulsed after reset deasserts, sample_valid SHALL stay 0 and all outputs SHALL match the reset values.
REQ-044 With enable deasserted 2 cycles after cos_start, exactly one sample SHALL be delivered and no further cos_start SHALL occur.
